// File: rtl/csi_pkt_tx.sv
// CSI-2 transmit packet builder: header + ECC, payload pass-through, CRC-16 footer.
// Optional header bit-error injection when PH_ERR_INJECT_EN is defined.
module csi_pkt_tx #(
  parameter logic [15:0] CRC_INIT    = 16'hFFFF,
  parameter logic [15:0] CRC_POLY_R  = 16'h8408,
  parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_vc,
  input  logic [5:0]  req_dt,
  input  logic [15:0] req_wc,
`ifdef PH_ERR_INJECT_EN
  input  logic        inj_en,
  input  logic [4:0]  inj_bit,
`endif
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    CRC
  } state_t;

  localparam logic [143:0] ECC_COL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F,
    6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26,
    6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13,
    6'h0E, 6'h0D, 6'h0B, 6'h07
  };

  function automatic logic [7:0] ecc_calc(
    input logic [23:0] d
  );
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) e = e ^ ECC_COL[i*6 +: 6];
    end
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ CRC_POLY_R;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic [31:0] hdr_q, hdr_d;
  logic [7:0]  txd_q, txd_d;
  logic        txv_q, txv_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;

  logic [23:0] hdr_data;
  logic [31:0] hdr_in;
  logic [31:0] inj_mask;
  logic [15:0] hdr_wc;
  logic        is_long;
  logic        load;
  logic [1:0]  idx_nxt;

  assign hdr_data = {req_wc, req_vc, req_dt};

`ifdef PH_ERR_INJECT_EN
  assign inj_mask = inj_en ? (32'd1 << inj_bit) : 32'd0;
`else
  assign inj_mask = 32'd0;
`endif

  // Flip happens after ECC so the receiver sees a genuine header error.
  assign hdr_in  = {ecc_calc(hdr_data), hdr_data} ^ inj_mask;
  assign hdr_wc  = hdr_q[23:8];
  assign is_long = hdr_q[5:0] >= LONG_DT_MIN;
  assign load    = !txv_q || tx_ready;
  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    crc_d     = crc_q;
    hdr_d     = hdr_q;
    txd_d     = txd_q;
    txv_d     = txv_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          hdr_d   = hdr_in;
          crc_d   = CRC_INIT;
          idx_d   = 2'd0;
          state_d = HDR;
          txv_d   = 1'b1;
          txd_d   = hdr_in[7:0];
          sop_d   = 1'b1;
          eop_d   = 1'b0;
        end
      end
      HDR: begin
        if (tx_ready) begin
          sop_d = 1'b0;
          if (idx_q != 2'd3) begin
            idx_d = idx_nxt;
            txd_d = hdr_q[{idx_nxt, 3'b000} +: 8];
            eop_d = !is_long && (idx_q == 2'd2);
          end else if (!is_long) begin
            state_d = IDLE;
            txv_d   = 1'b0;
            eop_d   = 1'b0;
          end else if (hdr_wc == 16'd0) begin
            state_d = CRC;
            idx_d   = 2'd0;
            txd_d   = crc_q[7:0];
          end else begin
            // First payload byte rides the ECC drain cycle.
            state_d  = PAY;
            pl_ready = 1'b1;
            if (pl_valid) begin
              txd_d = pl_data;
              crc_d = crc_byte(crc_q, pl_data);
              rem_d = hdr_wc - 16'd1;
            end else begin
              txv_d = 1'b0;
              rem_d = hdr_wc;
            end
          end
        end
      end
      PAY: begin
        if (load) begin
          if (rem_q != 16'd0) begin
            pl_ready = 1'b1;
            if (pl_valid) begin
              txv_d = 1'b1;
              txd_d = pl_data;
              crc_d = crc_byte(crc_q, pl_data);
              rem_d = rem_q - 16'd1;
            end else begin
              txv_d = 1'b0;
            end
          end else begin
            state_d = CRC;
            idx_d   = 2'd0;
            txv_d   = 1'b1;
            txd_d   = crc_q[7:0];
          end
        end
      end
      CRC: begin
        if (tx_ready) begin
          if (idx_q == 2'd0) begin
            idx_d = 2'd1;
            txd_d = crc_q[15:8];
            eop_d = 1'b1;
          end else begin
            state_d = IDLE;
            txv_d   = 1'b0;
            eop_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      req_ready = 1'b0;
      pl_ready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      rem_q   <= 16'd0;
      crc_q   <= CRC_INIT;
      hdr_q   <= 32'd0;
      txd_q   <= 8'd0;
      txv_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      hdr_q   <= hdr_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign tx_data  = txd_q;
  assign tx_valid = txv_q;
  assign tx_sop   = sop_q;
  assign tx_eop   = eop_q;

endmodule

// File: tb/tb_csi_pkt_tx.sv
// Scoreboard bench for csi_pkt_tx: directed packets, stalls, gaps, reset.
// Define PH_ERR_INJECT_EN to also cover header bit injection.
module tb_csi_pkt_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_vc;
  logic [5:0]  req_dt;
  logic [15:0] req_wc;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
`ifdef PH_ERR_INJECT_EN
  logic        inj_en;
  logic [4:0]  inj_bit;
`endif

  always #5 clk = ~clk;

  csi_pkt_tx dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_vc   (req_vc),
    .req_dt   (req_dt),
    .req_wc   (req_wc),
`ifdef PH_ERR_INJECT_EN
    .inj_en   (inj_en),
    .inj_bit  (inj_bit),
`endif
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop)
  );

  logic [9:0] exp_q[$];
  logic [7:0] pl_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int pl_acc  = 0;
  bit stall_en = 1'b0;
  bit gap_en   = 1'b0;
  bit pl_hs;
  logic       held, last_eop;
  logic [7:0] h_data;
  logic       h_sop, h_eop;
  logic [9:0] e_top;
  int cyc, base;

  logic [7:0] vec [24] = '{
    8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC,
    8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
    8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8,
    8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01
  };

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] expv);
    n_tests++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic logic [5:0] col_m(input int i);
    case (i)
      0: return 6'h07;   1: return 6'h0B;   2: return 6'h0D;
      3: return 6'h0E;   4: return 6'h13;   5: return 6'h15;
      6: return 6'h16;   7: return 6'h19;   8: return 6'h1A;
      9: return 6'h1C;  10: return 6'h23;  11: return 6'h25;
      12: return 6'h26; 13: return 6'h29;  14: return 6'h2A;
      15: return 6'h2C; 16: return 6'h31;  17: return 6'h32;
      18: return 6'h34; 19: return 6'h38;  20: return 6'h1F;
      21: return 6'h2F; 22: return 6'h37;  23: return 6'h3B;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [7:0] ecc_m(input logic [23:0] d);
    logic [5:0] e = 6'h00;
    for (int i = 0; i < 24; i++)
      if (d[i]) e = e ^ col_m(i);
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] crc_m(input logic [15:0] c,
                                        input logic [7:0] d);
    logic [15:0] r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic push(input logic [7:0] d, input logic s,
                      input logic e);
    exp_q.push_back({d, s, e});
  endtask

  task automatic push_hdr(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input logic lng);
    logic [23:0] d = {wc, vc, dt};
    push(d[7:0], 1'b1, 1'b0);
    push(d[15:8], 1'b0, 1'b0);
    push(d[23:16], 1'b0, 1'b0);
    push(ecc_m(d), 1'b0, !lng);
  endtask

  task automatic push_vec_pkt();
    push(8'h2B, 1'b1, 1'b0);
    push(8'h18, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    push(8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      push(vec[i], 1'b0, 1'b0);
      pl_q.push_back(vec[i]);
    end
    push(8'hF0, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b1);
  endtask

  task automatic push_rand_long(input logic [1:0] vc,
                                input logic [5:0] dt,
                                input logic [15:0] wc);
    logic [15:0] c = 16'hFFFF;
    logic [7:0] b;
    push_hdr(vc, dt, wc, 1'b1);
    for (int i = 0; i < int'(wc); i++) begin
      b = 8'($urandom);
      c = crc_m(c, b);
      push(b, 1'b0, 1'b0);
      pl_q.push_back(b);
    end
    push(c[7:0], 1'b0, 1'b0);
    push(c[15:8], 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [1:0] vc, input logic [5:0] dt,
                       input logic [15:0] wc);
    bit hs = 1'b0;
    @(posedge clk); #2;
    req_vc = vc; req_dt = dt; req_wc = wc;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk); #2;
    end
    req_valid = 1'b0;
    chk("req_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic drain(output int n, input int limit);
    @(negedge clk);
    chk("first_byte_latency", {30'd0, tx_valid, tx_sop}, 32'd3);
    n = 1;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    pl_valid = 1'b0;
    pl_data  = 8'h00;
    forever begin
      @(negedge clk);
      pl_hs = pl_valid && pl_ready;
      @(posedge clk); #1;
      if (pl_hs) begin
        pl_acc++;
        if (pl_q.size() > 0) void'(pl_q.pop_front());
      end
      pl_valid = pl_q.size() > 0 &&
                 (!gap_en || $urandom_range(0, 3) != 0);
      pl_data  = pl_q.size() > 0 ? pl_q[0] : 8'h00;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = !stall_en || ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    held = 1'b0;
    last_eop = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
        last_eop = 1'b0;
      end else begin
        if (held)
          chk("stall_hold", {21'd0, tx_valid, tx_data, tx_sop, tx_eop},
              {21'd0, 1'b1, h_data, h_sop, h_eop});
        if (last_eop)
          chk("idle_gap", {31'd0, tx_valid}, 32'd0);
        last_eop = 1'b0;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_byte", exp_q.size(), 1);
          end else begin
            e_top = exp_q.pop_front();
            chk("tx_byte", {22'd0, tx_data, tx_sop, tx_eop},
                {22'd0, e_top});
          end
          last_eop = tx_eop;
        end
        held   = tx_valid && !tx_ready;
        h_data = tx_data;
        h_sop  = tx_sop;
        h_eop  = tx_eop;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_vc = '0; req_dt = '0; req_wc = '0;
`ifdef PH_ERR_INJECT_EN
    inj_en = 1'b0; inj_bit = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_sop_eop", {30'd0, tx_sop, tx_eop}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    push(8'h00, 1'b1, 1'b0);
    push(8'h01, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    push(8'h1A, 1'b0, 1'b1);
    issue(2'd0, 6'h00, 16'h0001);
    drain(cyc, 200);
    chk("short_cycles", cyc, 4);

    push_vec_pkt();
    issue(2'd0, 6'h2B, 16'h0018);
    drain(cyc, 200);
    chk("long_cycles", cyc, 30);

    push_hdr(2'd0, 6'h2A, 16'h0000, 1'b1);
    push(8'hFF, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b1);
    issue(2'd0, 6'h2A, 16'h0000);
    drain(cyc, 200);
    chk("wc0_cycles", cyc, 6);

    stall_en = 1'b1;
    gap_en   = 1'b1;
    push_vec_pkt();
    issue(2'd0, 6'h2B, 16'h0018);
    drain(cyc, 1000);
    push_hdr(2'd3, 6'h05, 16'hA5C3, 1'b0);
    issue(2'd3, 6'h05, 16'hA5C3);
    drain(cyc, 200);
    push_rand_long(2'd2, 6'h1E, 16'd37);
    issue(2'd2, 6'h1E, 16'd37);
    drain(cyc, 2000);
    stall_en = 1'b0;
    gap_en   = 1'b0;

    base = pl_acc;
    push_vec_pkt();
    issue(2'd0, 6'h2B, 16'h0018);
    for (int i = 0; i < 200 && (pl_acc - base) < 10; i++) begin
      @(posedge clk); #2;
    end
    chk("reset_point", pl_acc - base, 10);
    reset = 1'b1;
    exp_q.delete();
    pl_q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_eop", {31'd0, tx_eop}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    push_hdr(2'd1, 6'h01, 16'h1234, 1'b0);
    issue(2'd1, 6'h01, 16'h1234);
    drain(cyc, 200);
    chk("post_rst_cycles", cyc, 4);

`ifdef PH_ERR_INJECT_EN
    inj_en = 1'b1;
    inj_bit = 5'd8;
    push(8'h00, 1'b1, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    push(8'h1A, 1'b0, 1'b1);
    issue(2'd0, 6'h00, 16'h0001);
    inj_en = 1'b0;
    drain(cyc, 200);
`endif

    push_rand_long(2'd1, 6'h2C, 16'hFFFF);
    issue(2'd1, 6'h2C, 16'hFFFF);
    drain(cyc, 70000);
    chk("wc_max_cycles", cyc, 65541);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
